// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: shared fetch configuration defaults and queue entry type
package ifu_prefetch_pkg;
   localparam int DEF_XLEN = 64;
   localparam int DEF_INST_LEN = 32;
   localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 64'h8000_0000;
   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_INST_LEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: memory, redirect and decode handshakes of the prefetch unit
interface ifu_prefetch_if #(
   parameter int XLEN = 64,
   parameter int INST_LEN = 32
);
   logic mem_req_valid, mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;
   logic redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic inst_valid, inst_ready;
   logic [XLEN-1:0] inst_pc;
   logic [INST_LEN-1:0] inst_data;
   modport master (
      output mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data,
      input mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, inst_ready
   );
   modport slave (
      input mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data,
      output mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/ifu_prefetch_sync_fifo_flush.sv
// ifu_prefetch_sync_fifo_flush: power-of-two FIFO with synchronous reset and flush
module ifu_prefetch_sync_fifo_flush #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic full,
   output logic empty,
   output logic [AW:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign rdata = mem[rd_ptr];
   // pointers and occupancy; flush empties the FIFO regardless of push/pop
   always_ff @(posedge clk)
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   // storage array needs no reset, occupancy guards every read
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-limited pipelined instruction prefetch with redirect flush
module ifu_prefetch import ifu_prefetch_pkg::*; #(
   parameter int XLEN = DEF_XLEN,
   parameter int INST_LEN = DEF_INST_LEN,
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic rst,
   ifu_prefetch_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [XLEN-1:0] fetch_pc, pend_pc;
   logic [CW-1:0] drop_cnt, outstanding, iq_count;
   logic pq_full, pq_empty, iq_full, iq_empty;
   logic req_fire, resp_fire, inst_fire;
   fetch_entry_t iq_in, iq_out;
   assign bus.mem_req_valid = !rst && drop_cnt == '0 &&
                              ({1'b0, iq_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
   assign bus.mem_req_addr = fetch_pc & ~XLEN'(7);
   assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
   assign resp_fire = bus.mem_resp_valid && drop_cnt == '0;
   assign bus.inst_valid = !rst && !iq_empty;
   assign inst_fire = bus.inst_valid && bus.inst_ready;
   assign iq_in = '{pc: pend_pc,
                    inst: pend_pc[2] ? bus.mem_resp_data[2*INST_LEN-1:INST_LEN] : bus.mem_resp_data[INST_LEN-1:0]};
   assign bus.inst_pc = iq_out.pc;
   assign bus.inst_data = iq_out.inst;
   // fetch PC and drain counter; a redirect overrides issue and folds in-flight requests into drop_cnt
   always_ff @(posedge clk)
      if (rst) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc <= bus.redirect_pc & ~XLEN'(3);
         drop_cnt <= drop_cnt + outstanding + CW'(req_fire) - CW'(bus.mem_resp_valid);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
         if (drop_cnt != '0 && bus.mem_resp_valid) drop_cnt <= drop_cnt - CW'(1);
      end
   // pending-PC FIFO; its occupancy is the outstanding-request count
   ifu_prefetch_sync_fifo_flush #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend (
      .clk(clk), .rst(rst), .flush(bus.redirect_valid), .push(req_fire), .pop(resp_fire),
      .wdata(fetch_pc), .rdata(pend_pc), .full(pq_full), .empty(pq_empty), .count(outstanding)
   );
   ifu_prefetch_sync_fifo_flush #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_iq (
      .clk(clk), .rst(rst), .flush(bus.redirect_valid), .push(resp_fire), .pop(inst_fire),
      .wdata(iq_in), .rdata(iq_out), .full(iq_full), .empty(iq_empty), .count(iq_count)
   );
   assert property (@(posedge clk) disable iff (rst) !(bus.mem_resp_valid && pq_empty && drop_cnt == '0));
   assert property (@(posedge clk) disable iff (rst) !(resp_fire && iq_full && !bus.redirect_valid));
   assert property (@(posedge clk) disable iff (rst) !(req_fire && pq_full && !bus.redirect_valid));
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: randomized scoreboard bench with an in-order memory model and PC-stream reference
module tb_ifu_prefetch;
   import ifu_prefetch_pkg::*;
   localparam int DEPTH = 4;
   localparam logic [63:0] RST_PC = DEF_RESET_PC;
   typedef struct { logic [63:0] addr; int due; } mreq_t;
   logic clk = 0, rst = 1, rst_nx = 1;
   mreq_t mq[$];
   logic [63:0] exp_q[$], acc_log[$];
   logic [63:0] next_pc = RST_PC, redir_tgt, tgt, prev_pc, exp_e, first_del;
   bit redir_pend, do_redir, prev_stall, cap_first;
   int checks = 0, failures = 0, cyc = 0, resp_cnt = 0, n_deliv = 0, first_v = -1;
   int lat_min = 1, lat_max = 1, p_req = 100, p_inst = 100, p_redir = 0;
   int rel, r0, f0, d0;
   always #5 clk = ~clk;
   ifu_prefetch_if #(.XLEN(64), .INST_LEN(32)) bus();
   ifu_prefetch #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic logic [31:0] h(logic [63:0] a);
      return a[31:0] * 32'h9E37_79B1 ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one clock: drive after the edge, account handshakes at the following negedge
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      rst = rst_nx;
      if (redir_pend) begin
         exp_q.delete();
         next_pc = redir_tgt;
         redir_pend = 0;
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back(next_pc);
         next_pc += 64'd4;
      end
      bus.mem_req_ready = $urandom_range(99) < p_req;
      bus.inst_ready = $urandom_range(99) < p_inst;
      bus.mem_resp_valid = mq.size() > 0 && mq[0].due <= cyc;
      bus.mem_resp_data = mq.size() > 0 ? {h(mq[0].addr + 64'd4), h(mq[0].addr)} : '0;
      if (p_redir > 0 && $urandom_range(999) < p_redir) begin
         do_redir = 1;
         tgt = {32'h0, 32'h8000_0000 + 32'($urandom_range(0, 4095))};
      end
      bus.redirect_valid = do_redir;
      bus.redirect_pc = tgt;
      do_redir = 0;
      @(negedge clk);
      if (rst) begin
         mq.delete();
         redir_pend = 1;
         redir_tgt = RST_PC;
      end else begin
         if (first_v < 0 && bus.inst_valid) first_v = cyc;
         if (bus.mem_resp_valid) begin
            void'(mq.pop_front());
            resp_cnt++;
         end
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            acc_log.push_back(bus.mem_req_addr);
            mq.push_back('{bus.mem_req_addr, cyc + int'($urandom_range(lat_min, lat_max))});
            chk("inflight_le_depth", 64'(mq.size() <= DEPTH), 64'd1);
         end
         if (bus.redirect_valid) begin
            redir_pend = 1;
            redir_tgt = tgt & ~64'd3;
         end
      end
   endtask

   task automatic do_reset();
      rst_nx = 1;
      repeat (2) step();
      rst_nx = 0;
      acc_log.delete();
   endtask

   // monitor: pops the expected PC stream on every decode handshake
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
         chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
      end else begin
         if (prev_stall) chk("head_stable", bus.inst_pc, prev_pc);
         if (bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL deliver: got pc %h expected none", bus.inst_pc);
            end else begin
               exp_e = exp_q.pop_front();
               chk("inst_pc", bus.inst_pc, exp_e);
               chk("inst_data", 64'(bus.inst_data), 64'(h(exp_e)));
               n_deliv++;
               if (cap_first) begin
                  first_del = bus.inst_pc;
                  cap_first = 0;
               end
            end
         end
      end
      prev_stall = !rst && bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
      prev_pc = bus.inst_pc;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      bus.mem_req_ready = 0; bus.inst_ready = 0; bus.mem_resp_valid = 0;
      bus.mem_resp_data = '0; bus.redirect_valid = 0; bus.redirect_pc = '0;
      // 1: zero-latency memory, full throughput
      rst_nx = 1;
      repeat (3) step();
      rst_nx = 0;
      acc_log.delete();
      first_v = -1;
      rel = cyc + 1;
      repeat (10) step();
      chk("first_valid_lat", 64'(first_v - rel), 64'd2);
      chk("t1_req_count", 64'(acc_log.size() >= 3), 64'd1);
      chk("t1_addr0", acc_log.size() > 0 ? acc_log[0] : '1, 64'h8000_0000);
      chk("t1_addr1", acc_log.size() > 1 ? acc_log[1] : '1, 64'h8000_0000);
      chk("t1_addr2", acc_log.size() > 2 ? acc_log[2] : '1, 64'h8000_0008);
      // 2: decode stalled, credit stops after DEPTH requests
      p_inst = 0;
      do_reset();
      repeat (12) step();
      chk("t2_req_count", 64'(acc_log.size()), 64'(DEPTH));
      chk("t2_req_valid", 64'(bus.mem_req_valid), 64'd0);
      chk("t2_head_pc", bus.inst_pc, RST_PC);
      d0 = n_deliv;
      p_inst = 100;
      repeat (10) step();
      chk("t2_drained", 64'(n_deliv - d0 >= DEPTH), 64'd1);
      // 3: three requests in flight at latency 3, redirect to a misaligned target
      lat_min = 3; lat_max = 3;
      do_reset();
      repeat (3) step();
      p_req = 0;
      r0 = resp_cnt;
      do_redir = 1;
      tgt = 64'h8000_1006;
      cap_first = 1;
      acc_log.delete();
      step();
      p_req = 100;
      for (int i = 0; i < 50 && acc_log.size() == 0; i++) step();
      chk("t3_drop_resps", 64'(resp_cnt - r0), 64'd3);
      chk("t3_first_addr", acc_log.size() > 0 ? acc_log[0] : '1, 64'h8000_1000);
      repeat (10) step();
      chk("t3_first_pc", first_del, 64'h8000_1004);
      // 4: redirect coincides with a response and a request handshake
      lat_min = 2; lat_max = 2;
      do_reset();
      repeat (2) step();
      r0 = resp_cnt;
      f0 = acc_log.size();
      do_redir = 1;
      tgt = 64'h8000_2000;
      step();
      chk("t4_same_cycle", 64'(acc_log.size() - f0 == 1 && resp_cnt - r0 == 1), 64'd1);
      acc_log.delete();
      r0 = resp_cnt;
      for (int i = 0; i < 50 && acc_log.size() == 0; i++) step();
      chk("t4_drop_resps", 64'(resp_cnt - r0), 64'd2);
      chk("t4_first_addr", acc_log.size() > 0 ? acc_log[0] : '1, 64'h8000_2000);
      repeat (10) step();
      // 5: reset with a full queue
      lat_min = 1; lat_max = 3;
      p_inst = 0;
      do_reset();
      repeat (15) step();
      chk("t5_full_valid", 64'(bus.inst_valid), 64'd1);
      chk("t5_full_noreq", 64'(bus.mem_req_valid), 64'd0);
      rst_nx = 1;
      step();
      chk("t5_rst_inst_valid", 64'(bus.inst_valid), 64'd0);
      chk("t5_rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
      rst_nx = 0;
      acc_log.delete();
      p_inst = 100;
      repeat (5) step();
      chk("t5_restart", acc_log.size() > 0 ? acc_log[0] : '1, RST_PC);
      // 6: random stalls, latencies and redirects over 1000 instructions
      lat_min = 1; lat_max = 4;
      p_req = 70; p_inst = 70; p_redir = 10;
      do_reset();
      d0 = n_deliv;
      for (int i = 0; i < 20000 && n_deliv - d0 < 1000; i++) step();
      chk("t6_delivered", 64'(n_deliv - d0 >= 1000), 64'd1);
      p_redir = 0;
      repeat (5) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor to the single-cycle DPI fetch block.
- Decouples PC generation from memory latency: issues pipelined instruction-fetch requests over a valid/ready memory port and buffers returned instructions in a DEPTH-entry queue.
- Hands instructions to decode with a valid/ready handshake.
- Supports PC redirect (branch/jump/trap), which flushes the queue and discards in-flight responses.
- Sits between the memory interface (DPI bridge or bus) and the decode stage.

Parameters:
- XLEN, 64, address and memory data width.
- INST_LEN, 32, instruction width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- DEPTH, 4, instruction-queue entries and max outstanding requests; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  fetch address, 8-byte aligned (pc & ~7).
- mem_resp_valid  in  1  response valid; responses return in request order; always accepted.
- mem_resp_data  in  XLEN  64-bit doubleword.
- redirect_valid  in  1  PC redirect strobe.
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (treated as 0).
- inst_valid  out  1  instruction available.
- inst_ready  in  1  decode accepts.
- inst_pc  out  XLEN  PC of presented instruction.
- inst_data  out  INST_LEN  instruction word.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC; queues empty; outstanding=0; drop_cnt=0.
  - mem_req_valid=0 and inst_valid=0 in the reset cycle and for all cycles while rst is held.
- Credit:
  - mem_req_valid=1 iff !rst && drop_cnt==0 && (queue_count + outstanding) < DEPTH.
  - The credit guarantees every response has a queue slot.
  - While the credit condition holds, mem_req_valid and mem_req_addr stay stable until handshake.
- Issue:
  - On req fire, push fetch_pc into the pending-PC FIFO (DEPTH entries), outstanding+1, fetch_pc+=4 (wraps mod 2^XLEN).
  - Back-to-back issue each cycle is allowed; throughput is 1/cycle.
- Response (when drop_cnt==0):
  - Pop pending PC p.
  - inst = p[2] ? data[63:32] : data[31:0].
  - Push {p, inst} into the instruction queue; outstanding-1.
  - Latency is one cycle: the response at edge N makes inst_valid=1 after edge N if the queue was empty.
- Output:
  - inst_valid = queue non-empty; inst_pc/inst_data = head entry.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle keep the count unchanged.
- Redirect (redirect_valid=1 at an edge), taking priority over all other events:
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - Instruction queue and pending FIFO cleared.
  - drop_cnt ← outstanding + req_fire − resp_fire, evaluated in that cycle; a request handshaking in the redirect cycle counts as in-flight.
  - outstanding ← 0.
  - A response arriving in the redirect cycle is discarded.
  - The inst pop in the redirect cycle is permitted, but the queue is empty afterwards.
- Draining (drop_cnt > 0):
  - Each mem_resp_valid decrements drop_cnt; the data is discarded.
  - No new requests are issued.
  - Fetch resumes the cycle after drop_cnt reaches 0.
- A redirect during draining adds the new cycle's req_fire (always 0 while draining) to drop_cnt and does not reset it.
- Queue full: inst_ready=0 holds the head stable; requests stop by credit, and no overflow is possible.
- Counter widths: $clog2(DEPTH)+1 bits for queue_count, outstanding and drop_cnt.
- Assertions (simulation only):
  - mem_resp_valid with outstanding==0 && drop_cnt==0 is an error.
  - A push into a full queue is an error.

Decomposition:
- Shared package (extend sysconfig):
  - RESET_PC default.
  - INST_LEN.
  - Typedef fetch_entry_t {pc, inst}.
- One sub-module: sync_fifo_flush.
  - Parametrised WIDTH/DEPTH; synchronous rst and flush.
  - Ports: push, pop, full, empty, count.
  - Instantiated twice: pending-PC FIFO and instruction queue.
- Credit, drop and PC logic live in ifu_prefetch.

Test Plan:
1. Reset, then zero-latency memory with mem_req_ready=1 and inst_ready=1.
   -> Addresses 0x8000_0000, 0x8000_0000, 0x8000_0008.
   -> inst_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 with low/high/low halves.
   -> First inst_valid 2 cycles after reset release.
2. inst_ready=0 with DEPTH=4.
   -> Exactly 4 requests issued; mem_req_valid stays 0.
   -> inst_pc stays 0x8000_0000 until ready=1, then drains in order.
3. Memory latency 3 cycles with 3 requests outstanding; redirect to 0x8000_1006.
   -> Next 3 responses discarded.
   -> Next request addr 0x8000_1000; first delivered inst_pc=0x8000_1004, upper half.
4. Redirect in the same cycle as a response and a request handshake.
   -> Response discarded; drop_cnt = old outstanding + 1 − 1.
   -> No stale PC reaches decode.
5. rst asserted mid-stream with a full queue.
   -> Next cycle: inst_valid=0, mem_req_valid=0.
   -> After release, fetch restarts at 0x8000_0000.
6. Random mem_req_ready/inst_ready stalls over 1000 instructions with a reference PC model.
   -> Delivered PC sequence strictly +4 between redirects; no drops, duplicates or overflow assertions.
